// File: rtl/bbox_overlay_pkg.sv
// -----------------------------------------------------------------------------
// bbox_overlay_pkg
// Shared definitions for the bounding-box overlay block:
//   - register map indices and the read-only ID value
//   - reset colour for the box outline
//   - box-coordinate packing widths and the box/ctrl record types
//   - helpers for packing coordinates into a register word and locating the
//     per-box register pair
// -----------------------------------------------------------------------------
package bbox_overlay_pkg;

    // Coordinate fields are 11 bits, each padded to a 16-bit half-word.
    localparam int COORD_W     = 11;
    localparam int COORD_PAD_W = 16 - COORD_W;

    // Largest representable line index; the line counter saturates here.
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    // Hardware supports at most this many boxes (CTRL mask is 4 bits).
    localparam int MAX_BOX = 4;

    // Register indices.
    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_COLOUR   = 4'd1;
    localparam logic [3:0] REG_STATUS   = 4'd2;
    localparam logic [3:0] REG_ID       = 4'd3;
    localparam logic [3:0] REG_BOX_BASE = 4'd4;

    localparam logic [31:0] BBOX_ID        = 32'h1234B0E1;
    localparam logic [23:0] BB_COL_DEFAULT = 24'h00ff00;

    // CTRL register layout: [5:4] outline thickness minus one, [3:0] box enables.
    typedef struct packed {
        logic [1:0]         thick_m1;
        logic [MAX_BOX-1:0] enable;
    } ctrl_t;

    // One box, corners inclusive.
    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] bottom;
    } box_t;

    // {pad, x, pad, y} as seen through the BOX_TL / BOX_BR registers.
    function automatic logic [31:0] pack_xy(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
        return {{COORD_PAD_W{1'b0}}, x, {COORD_PAD_W{1'b0}}, y};
    endfunction

    function automatic logic [3:0] box_tl_addr(input int i);
        return 4'(int'(REG_BOX_BASE) + 2 * i);
    endfunction

    function automatic logic [3:0] box_br_addr(input int i);
        return 4'(int'(REG_BOX_BASE) + 2 * i + 1);
    endfunction

endpackage

// File: rtl/bbox_hit.sv
// -----------------------------------------------------------------------------
// bbox_hit
// Combinational test of one pixel against one box outline. The pixel hits when
// the box is enabled, the pixel lies inside the (inclusive) box, and it is
// within thick_m1+1 pixels of at least one of the four edges.
//
// Ports:
//   enable    in   box enable from the active CTRL mask
//   x, y      in   pixel coordinate
//   box       in   active box corners
//   thick_m1  in   outline thickness minus one (0..3)
//   hit       out  pixel belongs to this box's outline
// -----------------------------------------------------------------------------
module bbox_hit
    import bbox_overlay_pkg::*;
(
    input  logic               enable,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  box_t               box,
    input  logic [1:0]         thick_m1,
    output logic               hit
);

    logic               in_x;
    logic               in_y;
    logic               near_edge;
    logic [COORD_W-1:0] d_left;
    logic [COORD_W-1:0] d_right;
    logic [COORD_W-1:0] d_top;
    logic [COORD_W-1:0] d_bottom;
    logic [COORD_W-1:0] t_lim;

    always_comb begin
        // An inverted box (left > right or top > bottom) can never satisfy
        // both range compares, so it is naturally excluded.
        in_x = (box.left <= x) && (x <= box.right);
        in_y = (box.top  <= y) && (y <= box.bottom);

        // Distances only matter once the pixel is inside, where they cannot
        // underflow.
        d_left   = x - box.left;
        d_right  = box.right - x;
        d_top    = y - box.top;
        d_bottom = box.bottom - y;

        // distance < thick_m1 + 1  <=>  distance <= thick_m1
        t_lim     = {{(COORD_W-2){1'b0}}, thick_m1};
        near_edge = (d_left <= t_lim) || (d_right  <= t_lim) ||
                    (d_top  <= t_lim) || (d_bottom <= t_lim);

        hit = enable && in_x && in_y && near_edge;
    end

endmodule

// File: rtl/bbox_overlay.sv
// -----------------------------------------------------------------------------
// bbox_overlay
// Streaming video filter that draws up to N_BOX rectangular outlines onto the
// pixels of video packets. Control registers are written through a memory-
// mapped slave into staged copies; the staged set is transferred into active
// shadow copies at every accepted video start-of-packet, so a frame is always
// drawn with one consistent register set.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   s_chipselect/s_read/s_write   MM slave strobes
//   s_address[3:0]                register index
//   s_writedata[31:0]             write data
//   s_readdata[31:0]              read data, valid one cycle after a read
//   sink_data[23:0], sink_valid,
//   sink_sop, sink_eop            input stream
//   sink_ready                    input back-pressure
//   source_data[23:0],
//   source_valid, source_sop,
//   source_eop                    output stream (one-cycle latency)
//   source_ready                  output back-pressure
//   mode                          1 = draw boxes, 0 = pass-through
// -----------------------------------------------------------------------------
module bbox_overlay #(
    parameter int          IMAGE_W        = 640,
    parameter int          IMAGE_H        = 480,
    parameter int          N_BOX          = 4,
    parameter logic [23:0] BB_COL_DEFAULT = bbox_overlay_pkg::BB_COL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [3:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,

    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,

    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,

    input  logic        mode
);

    import bbox_overlay_pkg::*;

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W:0]   Y_LIMIT = (COORD_W + 1)'(IMAGE_H);

    // -------------------------------------------------------------------------
    // Stream handshake and beat classification
    // -------------------------------------------------------------------------
    logic accept;
    logic sop_is_video;
    logic beat_video;
    logic video_sop_acc;
    logic pixel_acc;
    logic pkt_video;

    assign sink_ready    = ~source_valid | source_ready;
    assign accept        = sink_valid & sink_ready;
    assign sop_is_video  = (sink_data[3:0] == 4'h0);
    // A sop beat classifies its own packet; later beats use the stored class.
    assign beat_video    = sink_sop ? sop_is_video : pkt_video;
    assign video_sop_acc = accept & sink_sop & sop_is_video;
    assign pixel_acc     = accept & ~sink_sop & pkt_video;

    // -------------------------------------------------------------------------
    // Register file: staged (software-visible) and shadow (drawing) copies
    // -------------------------------------------------------------------------
    ctrl_t       ctrl_stg;
    ctrl_t       ctrl_shd;
    logic [23:0] colour_stg;
    logic [23:0] colour_shd;
    box_t        box_stg [N_BOX];
    box_t        box_shd [N_BOX];

    logic        reg_wr;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign reg_wr = s_chipselect & s_write;

    // Top bits of the write word carry no register field.
    assign unused_wdata = ^s_writedata[31:27];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_stg   <= '0;
            ctrl_shd   <= '0;
            colour_stg <= BB_COL_DEFAULT;
            colour_shd <= BB_COL_DEFAULT;
            // NOTE: the box arrays are a handful of flops, not a RAM, so
            // they are reset explicitly; a true memory would be left
            // unreset and initialised by software instead.
            for (int i = 0; i < N_BOX; i++) begin
                box_stg[i] <= '0;
                box_shd[i] <= '0;
            end
        end else begin
            if (reg_wr && (s_address == REG_CTRL)) begin
                ctrl_stg <= ctrl_t'(s_writedata[5:0]);
            end
            if (reg_wr && (s_address == REG_COLOUR)) begin
                colour_stg <= s_writedata[23:0];
            end
            // Addresses for boxes >= N_BOX match no slot and are dropped.
            for (int i = 0; i < N_BOX; i++) begin
                if (reg_wr && (s_address == box_tl_addr(i))) begin
                    box_stg[i].left <= s_writedata[16 +: COORD_W];
                    box_stg[i].top  <= s_writedata[0  +: COORD_W];
                end
                if (reg_wr && (s_address == box_br_addr(i))) begin
                    box_stg[i].right  <= s_writedata[16 +: COORD_W];
                    box_stg[i].bottom <= s_writedata[0  +: COORD_W];
                end
            end

            // The staged set is sampled before any same-cycle write lands,
            // so a write coinciding with sop applies from the next frame.
            if (video_sop_acc) begin
                ctrl_shd   <= ctrl_stg;
                colour_shd <= colour_stg;
                for (int i = 0; i < N_BOX; i++) begin
                    box_shd[i] <= box_stg[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame tracking: pixel position, packet class, frame status
    // -------------------------------------------------------------------------
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic               in_frame;
    logic [15:0]        frame_count;

    // NOTE: all state here uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_pos       <= '0;
            y_pos       <= '0;
            pkt_video   <= 1'b0;
            in_frame    <= 1'b0;
            frame_count <= '0;
        end else if (accept) begin
            if (sink_sop) begin
                pkt_video <= sop_is_video;
                x_pos     <= '0;
                y_pos     <= '0;
            end else if (pkt_video) begin
                if (x_pos == X_LAST) begin
                    x_pos <= '0;
                    // An overrunning frame parks at the last line rather than
                    // wrapping back into the box area.
                    if (y_pos != COORD_MAX) begin
                        y_pos <= y_pos + 1'b1;
                    end
                end else begin
                    x_pos <= x_pos + 1'b1;
                end
            end

            // A repeated sop simply re-arms in_frame; only eop counts frames.
            if (sink_eop && beat_video) begin
                in_frame    <= 1'b0;
                frame_count <= frame_count + 16'd1;
            end else if (video_sop_acc) begin
                in_frame <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Box hit detection and pixel replacement
    // -------------------------------------------------------------------------
    logic [N_BOX-1:0] box_hit;
    logic             in_image;
    logic             draw;
    logic [23:0]      pix_out;

    for (genvar g = 0; g < N_BOX; g++) begin : g_box
        bbox_hit u_hit (
            .enable   (ctrl_shd.enable[g]),
            .x        (x_pos),
            .y        (y_pos),
            .box      (box_shd[g]),
            .thick_m1 (ctrl_shd.thick_m1),
            .hit      (box_hit[g])
        );
    end

    // Lines past the configured height are overrun pixels and never drawn.
    assign in_image = ({1'b0, y_pos} < Y_LIMIT);
    assign draw     = pkt_video & ~sink_sop & mode & in_image & (|box_hit);
    assign pix_out  = draw ? colour_shd : sink_data;

    // -------------------------------------------------------------------------
    // Output register: loads whenever the slot is empty or being drained,
    // and holds while the downstream stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_valid <= 1'b0;
            source_data  <= '0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else if (sink_ready) begin
            source_valid <= sink_valid;
            source_data  <= pix_out;
            source_sop   <= sink_sop;
            source_eop   <= sink_eop;
        end
    end

    // -------------------------------------------------------------------------
    // Register read path
    // -------------------------------------------------------------------------
    // NOTE: rd_mux gets a default before the case so every path assigns it
    // and no latch is inferred for unmapped addresses.
    always_comb begin
        rd_mux = '0;
        case (s_address)
            REG_CTRL:   rd_mux = {26'b0, ctrl_stg};
            REG_COLOUR: rd_mux = {8'b0, colour_stg};
            REG_STATUS: rd_mux = {15'b0, in_frame, frame_count};
            REG_ID:     rd_mux = BBOX_ID;
            default: begin
                for (int i = 0; i < N_BOX; i++) begin
                    if (s_address == box_tl_addr(i)) begin
                        rd_mux = pack_xy(box_stg[i].left, box_stg[i].top);
                    end
                    if (s_address == box_br_addr(i)) begin
                        rd_mux = pack_xy(box_stg[i].right, box_stg[i].bottom);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_readdata <= '0;
        end else if (s_chipselect && s_read) begin
            s_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bbox_overlay.sv
// -----------------------------------------------------------------------------
// tb_bbox_overlay
// Randomised stimulus with a scoreboard. The driver computes each expected
// output beat from a geometric model of the boxes and queues it; a monitor
// pops and compares on every output handshake. A reduced image size keeps
// whole frames short.
// -----------------------------------------------------------------------------
module tb_bbox_overlay;

    localparam int IMG_W = 40;
    localparam int IMG_H = 44;
    localparam int NB    = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_chipselect, s_read, s_write;
    logic [3:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [23:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop, sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready;
    logic        mode;

    always #5 clk = ~clk;

    bbox_overlay #(
        .IMAGE_W        (IMG_W),
        .IMAGE_H        (IMG_H),
        .N_BOX          (NB),
        .BB_COL_DEFAULT (24'h00ff00)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_chipselect (s_chipselect),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_address    (s_address),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready),
        .mode         (mode)
    );

    int checks = 0;
    int errors = 0;

    // Expected output beats: {sop, eop, data}.
    logic [25:0] sb_q[$];

    // Reference model: staged registers, frame snapshot, frame counter.
    int m_ctrl, m_col;
    int m_left[NB], m_top[NB], m_right[NB], m_bot[NB];
    int sh_ctrl, sh_col;
    int sh_left[NB], sh_top[NB], sh_right[NB], sh_bot[NB];
    int frames;
    bit rdy_random = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: one comparison per completed output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && source_valid && source_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", {6'b0, source_sop, source_eop, source_data}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_beat", {6'b0, source_sop, source_eop, source_data},
                          {6'b0, sb_q.pop_front()});
                end
            end
        end
    end

    // Downstream back-pressure.
    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] xy(input int x, input int y);
        return {5'b0, 11'(x), 5'b0, 11'(y)};
    endfunction

    // Geometric rule for one pixel against the frame snapshot.
    function automatic bit model_hit(input int x, input int y);
        int t;
        if (y >= IMG_H) return 1'b0;
        t = ((sh_ctrl >> 4) & 3) + 1;
        for (int i = 0; i < NB; i++) begin
            if (((sh_ctrl >> i) & 1) != 0 &&
                sh_left[i] <= x && x <= sh_right[i] &&
                sh_top[i]  <= y && y <= sh_bot[i] &&
                (x - sh_left[i] < t || sh_right[i] - x < t ||
                 y - sh_top[i]  < t || sh_bot[i]  - y < t))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_col = 'h00ff00; frames = 0;
        for (int i = 0; i < NB; i++) begin
            m_left[i] = 0; m_top[i] = 0; m_right[i] = 0; m_bot[i] = 0;
        end
    endtask

    task automatic reg_write(input int a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = 4'(a); s_writedata = d;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_write = 1'b0;
        if (a == 0) m_ctrl = int'(d & 32'h3F);
        else if (a == 1) m_col = int'(d & 32'hFF_FFFF);
        else if (a >= 4 && a < 4 + 2 * NB) begin
            if ((a % 2) == 0) begin
                m_left[(a - 4) / 2] = int'((d >> 16) & 32'h7FF);
                m_top[(a - 4) / 2]  = int'(d & 32'h7FF);
            end else begin
                m_right[(a - 4) / 2] = int'((d >> 16) & 32'h7FF);
                m_bot[(a - 4) / 2]   = int'(d & 32'h7FF);
            end
        end
    endtask

    task automatic set_box(input int i, input int l, input int t, input int r, input int b);
        reg_write(4 + 2 * i, xy(l, t));
        reg_write(5 + 2 * i, xy(r, b));
    endtask

    task automatic reg_read_check(input int a, input logic [31:0] exp, input string name);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = 4'(a);
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_read = 1'b0;
        check(name, s_readdata, exp);
    endtask

    task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop,
                             input logic [23:0] exp_d);
        int n;
        sb_q.push_back({sop, eop, exp_d});
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sink_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!sink_ready) begin
            $display("FAIL sink_ready_timeout actual=0 expected=1");
            $fatal(1, "sink stalled");
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    // One video frame of 'lines' lines. At pixel mid_idx (if >= 0) a register
    // write and a STATUS read are slotted in while the frame is open.
    task automatic send_frame(input int lines, input int mid_idx, input int mid_addr,
                              input logic [31:0] mid_data);
        logic [23:0] d;
        int npix;
        sh_ctrl = m_ctrl; sh_col = m_col;
        for (int i = 0; i < NB; i++) begin
            sh_left[i] = m_left[i]; sh_top[i] = m_top[i];
            sh_right[i] = m_right[i]; sh_bot[i] = m_bot[i];
        end
        d = 24'($urandom) & 24'hFFFFF0;
        send_beat(d, 1'b1, 1'b0, d);
        npix = lines * IMG_W;
        for (int idx = 0; idx < npix; idx++) begin
            d = 24'($urandom);
            send_beat(d, 1'b0, idx == npix - 1,
                      (mode && model_hit(idx % IMG_W, idx / IMG_W)) ? 24'(sh_col) : d);
            if (idx == mid_idx) begin
                reg_write(mid_addr, mid_data);
                reg_read_check(2, {15'b0, 1'b1, 16'(frames)}, "status_in_frame");
            end
        end
        frames++;
    endtask

    task automatic send_raw(input int len, input bit with_sop);
        logic [23:0] d;
        for (int k = 0; k < len; k++) begin
            d = 24'($urandom);
            if (k == 0 && with_sop) d = d | 24'hF;
            send_beat(d, with_sop && k == 0, k == len - 1, d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || source_valid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, sb_q.size(), 0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0; mode = 1'b0;
        s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
        sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // Reset state.
        check("rst_source_valid", {31'b0, source_valid}, 32'h0);
        check("rst_readdata", s_readdata, 32'h0);
        reg_read_check(0, 32'h0, "rst_ctrl");
        reg_read_check(1, 32'h00ff00, "rst_colour");
        reg_read_check(2, 32'h0, "rst_status");
        reg_read_check(4, 32'h0, "rst_box0_tl");
        reg_read_check(3, 32'h1234B0E1, "id");

        // Register map round trips and unmapped addresses.
        set_box(0, 10, 20, 30, 40);
        reg_read_check(4, xy(10, 20), "box0_tl_rb");
        reg_read_check(5, xy(30, 40), "box0_br_rb");
        reg_write(12, 32'hFFFF_FFFF);
        reg_read_check(12, 32'h0, "unmapped_12");
        reg_write(2, 32'hFFFF_FFFF);
        reg_read_check(2, 32'h0, "status_ro");
        reg_write(0, 32'h01);
        reg_read_check(0, 32'h01, "ctrl_rb");

        // Single box, thickness 1, ready always high.
        mode = 1'b1;
        send_frame(IMG_H, -1, 0, 0);

        // Thickness 4, random back-pressure.
        rdy_random = 1'b1;
        reg_write(0, 32'h31);
        send_frame(IMG_H, -1, 0, 0);

        // Mid-frame box move: visible only from the following frame.
        send_frame(IMG_H, 300, 4, xy(2, 3));
        send_frame(IMG_H, -1, 0, 0);

        // Non-video packet must pass untouched and not count.
        send_raw(25, 1'b1);
        wait_drain("drain_nonvideo");
        reg_read_check(2, {16'b0, 16'(frames)}, "status_after_nonvideo");

        // Random boxes, colour and thickness, including inverted boxes.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB; i++) begin
                set_box(i, $urandom_range(0, 45), $urandom_range(0, 50),
                           $urandom_range(0, 45), $urandom_range(0, 50));
            end
            reg_write(1, 32'($urandom) & 32'hFF_FFFF);
            reg_write(0, 32'($urandom_range(0, 63)));
            send_frame(IMG_H, -1, 0, 0);
        end

        // Pass-through mode.
        mode = 1'b0;
        send_frame(IMG_H, -1, 0, 0);
        mode = 1'b1;

        // Inverted boxes only: left > right and top > bottom.
        set_box(1, 35, 10, 25, 30);
        set_box(2, 5, 30, 20, 10);
        reg_write(0, 32'h26);
        send_frame(IMG_H, -1, 0, 0);

        // Overrun frame: the box extends past the last line.
        set_box(0, 0, 40, IMG_W - 1, 2047);
        reg_write(0, 32'h31);
        send_frame(IMG_H + 4, -1, 0, 0);
        wait_drain("drain_frames");
        reg_read_check(2, {16'b0, 16'(frames)}, "status_frame_count");

        // Reset in the middle of a video packet; the tail must be non-video.
        send_beat(24'h123450, 1'b1, 1'b0, 24'h123450);
        send_raw(5, 1'b0);
        wait_drain("drain_before_reset");
        apply_reset();
        reg_write(0, 32'h31);
        reg_write(1, 32'hABCDEF);
        set_box(0, 0, 0, IMG_W - 1, IMG_H - 1);
        send_raw(8, 1'b0);
        wait_drain("drain_after_reset");
        reg_read_check(2, 32'h0, "status_after_reset");

        // Recovery: a full frame after reset draws with the new settings.
        send_frame(IMG_H, -1, 0, 0);
        wait_drain("drain_final");
        reg_read_check(2, {16'b0, 16'(frames)}, "status_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
